bio_gpio_irq_apb: RTL and testbench
===================================

BIO_GPIO_IRQ_APB -- requirements
Module: bio_gpio_irq_apb

Interface
REQ-001 Parameter NPIN, default 32, number of GPIO pins (legal 1..32).
REQ-002 Parameter NIRQ, default 4, number of interrupt outputs (legal 1..8).
REQ-003 Parameter AW, default 12, APB address width.
REQ-004 Parameter SYNC_STAGES, default 2, input synchroniser depth (legal 2..4).
REQ-005 Ports, in order: pclk in 1, the single clock; reset in 1, asynchronous active-high reset.
REQ-006 gpio_in in NPIN, asynchronous pad inputs; gpio_out out NPIN, output values; gpio_dir out NPIN, output enables (1=drive); irq out NIRQ, level interrupts.
REQ-007 PADDR in AW; PSEL, PENABLE, PWRITE in 1; PSTRB in 4; PWDATA in 32; PRDATA out 32; PREADY out 1; PSLVERR out 1.

Function
REQ-008 APB access phase = PSEL&PENABLE; PREADY SHALL be 1 always (zero wait states); writes commit at the pclk edge ending the access phase.
REQ-009 Register map (word offsets, PADDR[1:0] ignored): 0x00 OUT rw; 0x04 DIR rw; 0x08 IN ro; 0x0C OUT_SET wo; 0x10 OUT_CLR wo; 0x14 RISE_EN rw; 0x18 FALL_EN rw; 0x1C STATUS ro/W1C; 0x20+4k MASK[k] rw for k<NIRQ.
REQ-010 Writes to rw registers SHALL honour PSTRB per byte; OUT_SET/OUT_CLR/STATUS W1C act only on bytes with PSTRB set.
REQ-011 Bits at index >= NPIN SHALL read 0 and ignore writes in every register.
REQ-012 PRDATA SHALL be the addressed register during a read access phase, 0 otherwise; write-only registers read 0.
REQ-013 Access to an unmapped offset (including MASK[k], k>=NIRQ) SHALL assert PSLVERR for that access phase, read 0, and have no side effect.
REQ-014 gpio_out = OUT, gpio_dir = DIR, driven from registers with no combinational path from APB inputs.
REQ-015 OUT_SET write: OUT |= data; OUT_CLR write: OUT &= ~data; the update is visible on gpio_out the cycle after the commit edge.
REQ-016 Each gpio_in bit passes through SYNC_STAGES flops; IN = final stage; a level sampled at edge N reads in IN after edge N+SYNC_STAGES-1.
REQ-017 A PREV register holds IN delayed by one cycle; rise[i] = IN[i]&~PREV[i]&RISE_EN[i]; fall[i] = ~IN[i]&PREV[i]&FALL_EN[i].
REQ-018 STATUS[i] SHALL set on the edge following rise[i]|fall[i] and stay set until cleared by a W1C write of 1.
REQ-019 If a set event and a W1C clear of the same bit occur in the same cycle, the set SHALL win (STATUS remains 1).
REQ-020 irq[k] SHALL be registered: irq[k] <= |(STATUS & MASK[k]), one cycle after STATUS/MASK change.
REQ-021 End-to-end: with SYNC_STAGES=2 and RISE_EN set, a rising gpio_in sampled at edge N sets STATUS after edge N+2 and irq after edge N+3.
REQ-022 Enabling RISE_EN/FALL_EN while the pin is static SHALL NOT set STATUS; only transitions of IN after enable count.

Reset
REQ-023 While reset is high, all flops (synchronisers, IN, PREV, OUT, DIR, RISE_EN, FALL_EN, STATUS, MASK[*], irq) SHALL be 0 asynchronously; gpio_out=0, gpio_dir=0, irq=0, PRDATA=0, PSLVERR=0.
REQ-024 A pin held high across reset deassertion MAY produce a rise event only if RISE_EN[i] is set by the time IN rises; with RISE_EN=0 at reset, no STATUS bit sets.
REQ-025 Reset asserted mid-transfer SHALL abort it with no register side effect.

Verification
REQ-026 Write OUT=0xA5A5_0000 with PSTRB=4'b1100, then OUT_SET=0x1, OUT_CLR=0x8000_0000 -> gpio_out=0x25A5_0001, PSLVERR=0 throughout.
REQ-027 RISE_EN[3]=1, MASK[1]=0x8, gpio_in[3] 0->1 at edge N -> STATUS=0x8 after N+2, irq=4'b0010 after N+3; W1C 0x8 -> irq=0 two edges later.
REQ-028 FALL_EN[0]=1, STATUS[0]=1; W1C of bit 0 in the same cycle as a new falling event -> STATUS[0] stays 1.
REQ-029 NPIN=8, NIRQ=2: write 0xFFFF_FFFF to DIR, read 0xFF; read offset 0x28 -> PRDATA=0, PSLVERR=1, no state change.
REQ-030 Assert reset during a write access phase to OUT=0xFFFF_FFFF with irq active -> after release OUT=0, irq=0, all registers read 0.

Source files
------------

// File: rtl/bio_gpio_irq_apb.sv
// APB-programmable GPIO block: output/direction registers, synchronised inputs,
// per-pin rise/fall capture into a W1C status register and maskable level interrupts.
module bio_gpio_irq_apb #(
  parameter int NPIN        = 32,
  parameter int NIRQ        = 4,
  parameter int AW          = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic            pclk,
  input  logic            reset,
  input  logic [NPIN-1:0] gpio_in,
  output logic [NPIN-1:0] gpio_out,
  output logic [NPIN-1:0] gpio_dir,
  output logic [NIRQ-1:0] irq,
  input  logic [AW-1:0]   PADDR,
  input  logic            PSEL,
  input  logic            PENABLE,
  input  logic            PWRITE,
  input  logic [3:0]      PSTRB,
  input  logic [31:0]     PWDATA,
  output logic [31:0]     PRDATA,
  output logic            PREADY,
  output logic            PSLVERR
);

  localparam logic [31:0] W_OUT     = 32'd0;
  localparam logic [31:0] W_DIR     = 32'd1;
  localparam logic [31:0] W_IN      = 32'd2;
  localparam logic [31:0] W_OUT_SET = 32'd3;
  localparam logic [31:0] W_OUT_CLR = 32'd4;
  localparam logic [31:0] W_RISE_EN = 32'd5;
  localparam logic [31:0] W_FALL_EN = 32'd6;
  localparam logic [31:0] W_STATUS  = 32'd7;
  localparam logic [31:0] W_MASK0   = 32'd8;
  localparam logic [31:0] W_END     = 32'(8 + NIRQ);

  logic [NPIN-1:0] sync_q [SYNC_STAGES];
  logic [NPIN-1:0] sync_d [SYNC_STAGES];
  logic [NPIN-1:0] prev_q, prev_d;
  logic [NPIN-1:0] out_q, out_d;
  logic [NPIN-1:0] dir_q, dir_d;
  logic [NPIN-1:0] rise_en_q, rise_en_d;
  logic [NPIN-1:0] fall_en_q, fall_en_d;
  logic [NPIN-1:0] status_q, status_d;
  logic [NPIN-1:0] mask_q [NIRQ];
  logic [NPIN-1:0] mask_d [NIRQ];
  logic [NIRQ-1:0] irq_q, irq_d;

  logic [NPIN-1:0] in_w, event_w, wmask_w, wdata_w, rdata_w;
  logic [31:0]     word_idx, strb_mask;
  logic            access, mapped, wr_en, rd_en;
  logic            unused_bits;

  assign unused_bits = ^{PADDR[1:0], PWDATA, strb_mask};

  // Decode; reset gates the access so an interrupted transfer has no effect.
  always_comb begin
    word_idx = '0;
    word_idx[AW-3:0] = PADDR[AW-1:2];
    access = PSEL & PENABLE & ~reset;
    mapped = (word_idx < W_END);
    wr_en  = access & PWRITE & mapped;
    rd_en  = access & ~PWRITE & mapped;
    strb_mask = '0;
    for (int b = 0; b < 4; b++) begin
      strb_mask[8*b +: 8] = {8{PSTRB[b]}};
    end
    wmask_w = strb_mask[NPIN-1:0];
    wdata_w = PWDATA[NPIN-1:0] & wmask_w;
  end

  always_comb begin
    sync_d[0] = gpio_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign in_w = sync_q[SYNC_STAGES-1];

  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    status_d  = status_q;
    for (int k = 0; k < NIRQ; k++) begin
      mask_d[k] = mask_q[k];
    end
    prev_d  = in_w;
    event_w = (in_w & ~prev_q & rise_en_q) | (~in_w & prev_q & fall_en_q);
    if (wr_en) begin
      case (word_idx)
        W_OUT:     out_d     = (out_q & ~wmask_w) | wdata_w;
        W_DIR:     dir_d     = (dir_q & ~wmask_w) | wdata_w;
        W_OUT_SET: out_d     = out_q | wdata_w;
        W_OUT_CLR: out_d     = out_q & ~wdata_w;
        W_RISE_EN: rise_en_d = (rise_en_q & ~wmask_w) | wdata_w;
        W_FALL_EN: fall_en_d = (fall_en_q & ~wmask_w) | wdata_w;
        W_STATUS:  status_d  = status_q & ~wdata_w;
        default: begin
          for (int k = 0; k < NIRQ; k++) begin
            if (word_idx == W_MASK0 + 32'(k)) begin
              mask_d[k] = (mask_q[k] & ~wmask_w) | wdata_w;
            end
          end
        end
      endcase
    end
    // Applied after the W1C so a coincident new edge keeps the bit set.
    status_d = status_d | event_w;
  end

  for (genvar gi = 0; gi < NIRQ; gi++) begin : g_irq
    assign irq_d[gi] = |(status_q & mask_q[gi]);
  end

  always_comb begin
    rdata_w = '0;
    if (rd_en) begin
      case (word_idx)
        W_OUT:     rdata_w = out_q;
        W_DIR:     rdata_w = dir_q;
        W_IN:      rdata_w = in_w;
        W_RISE_EN: rdata_w = rise_en_q;
        W_FALL_EN: rdata_w = fall_en_q;
        W_STATUS:  rdata_w = status_q;
        default: begin
          for (int k = 0; k < NIRQ; k++) begin
            if (word_idx == W_MASK0 + 32'(k)) begin
              rdata_w = mask_q[k];
            end
          end
        end
      endcase
    end
    PRDATA = '0;
    PRDATA[NPIN-1:0] = rdata_w;
  end

  assign PSLVERR  = access & ~mapped;
  assign PREADY   = 1'b1;
  assign gpio_out = out_q;
  assign gpio_dir = dir_q;
  assign irq      = irq_q;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q    <= '0;
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      for (int k = 0; k < NIRQ; k++) begin
        mask_q[k] <= '0;
      end
      irq_q     <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      prev_q    <= prev_d;
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      for (int k = 0; k < NIRQ; k++) begin
        mask_q[k] <= mask_d[k];
      end
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_bio_gpio_irq_apb.sv
// Directed and randomised checks of bio_gpio_irq_apb against a register-level model.
module tb_bio_gpio_irq_apb;

  localparam logic [11:0] A_OUT = 12'h000, A_DIR = 12'h004, A_IN  = 12'h008;
  localparam logic [11:0] A_SET = 12'h00C, A_CLR = 12'h010, A_REN = 12'h014;
  localparam logic [11:0] A_FEN = 12'h018, A_ST  = 12'h01C, A_M0  = 12'h020;
  localparam logic [11:0] A_M1  = 12'h024, A_M2  = 12'h028, A_M3  = 12'h02C;

  logic        pclk = 1'b0;
  logic        reset;
  logic [31:0] gpio_in, gpio_out, gpio_dir;
  logic [3:0]  irq;
  logic [11:0] PADDR;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [3:0]  PSTRB;
  logic [31:0] PWDATA, PRDATA;

  logic [7:0]  s_gpio_in, s_gpio_out, s_gpio_dir;
  logic [1:0]  s_irq;
  logic [11:0] s_paddr;
  logic        s_psel, s_penable, s_pwrite, s_pready, s_pslverr;
  logic [3:0]  s_pstrb;
  logic [31:0] s_pwdata, s_prdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] out_m, dir_m, ren_m, fen_m, st_m;
  logic [31:0] mask_m [4];

  always #5 pclk = ~pclk;

  bio_gpio_irq_apb u_dut (
    .pclk(pclk), .reset(reset), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_dir(gpio_dir), .irq(irq), .PADDR(PADDR), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PSTRB(PSTRB), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  bio_gpio_irq_apb #(.NPIN(8), .NIRQ(2)) u_small (
    .pclk(pclk), .reset(reset), .gpio_in(s_gpio_in), .gpio_out(s_gpio_out),
    .gpio_dir(s_gpio_dir), .irq(s_irq), .PADDR(s_paddr), .PSEL(s_psel),
    .PENABLE(s_penable), .PWRITE(s_pwrite), .PSTRB(s_pstrb), .PWDATA(s_pwdata),
    .PRDATA(s_prdata), .PREADY(s_pready), .PSLVERR(s_pslverr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] byte_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // Called 1 time unit after a rising edge; returns 1 unit after the commit edge.
  task automatic apb(input logic w, input logic [11:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r, output logic e);
    PADDR = a; PWRITE = w; PWDATA = d; PSTRB = s; PSEL = 1'b1; PENABLE = 1'b0;
    #1;
    chk("prdata_setup_zero", PRDATA, 32'h0);
    @(posedge pclk); #1;
    PENABLE = 1'b1;
    #1;
    r = PRDATA;
    e = PSLVERR;
    @(posedge pclk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    logic e;
    apb(1'b1, a, d, s, r, e);
    chk("wr_pslverr", {31'h0, e}, 32'h0);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic e;
    apb(1'b0, a, 32'h0, 4'hF, r, e);
    chk(tag, r, exp);
    chk({tag, "_pslverr"}, {31'h0, e}, 32'h0);
  endtask

  task automatic s_apb(input logic w, input logic [11:0] a, input logic [31:0] d,
                       output logic [31:0] r, output logic e);
    s_paddr = a; s_pwrite = w; s_pwdata = d; s_pstrb = 4'hF; s_psel = 1'b1; s_penable = 1'b0;
    @(posedge pclk); #1;
    s_penable = 1'b1;
    #1;
    r = s_prdata;
    e = s_pslverr;
    @(posedge pclk); #1;
    s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0;
  endtask

  initial begin
    logic [31:0] r, d, bm, newg, oldg, ev, exp_rb;
    logic [11:0] addr, rb_addr;
    logic [3:0]  s, exp_irq;
    logic        e;
    int          sel;

    reset = 1'b1; gpio_in = '0; PADDR = '0; PSEL = 0; PENABLE = 0; PWRITE = 0;
    PSTRB = '0; PWDATA = '0;
    s_gpio_in = '0; s_paddr = '0; s_psel = 0; s_penable = 0; s_pwrite = 0;
    s_pstrb = '0; s_pwdata = '0;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_gpio_out", gpio_out, 32'h0);
    chk("rst_gpio_dir", gpio_dir, 32'h0);
    chk("rst_irq", {28'h0, irq}, 32'h0);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_pslverr", {31'h0, PSLVERR}, 32'h0);
    chk("pready", {31'h0, PREADY}, 32'h1);
    reset = 1'b0;

    // Byte strobes, set and clear.
    wr(A_OUT, 32'hA5A5_A5A5, 4'b1100);
    chk("out_strobe", gpio_out, 32'hA5A5_0000);
    wr(A_SET, 32'h0000_0001, 4'hF);
    chk("out_set", gpio_out, 32'hA5A5_0001);
    wr(A_CLR, 32'h8000_0000, 4'hF);
    chk("out_clr", gpio_out, 32'h25A5_0001);
    rd_chk("out_read", A_OUT, 32'h25A5_0001);
    rd_chk("set_reads_zero", A_SET, 32'h0);

    // Synchroniser latency: sampled at N, visible in IN after N+1.
    gpio_in = 32'h0001_0000;
    apb(1'b0, A_IN, 32'h0, 4'hF, r, e);
    chk("in_not_yet", r, 32'h0);
    gpio_in = 32'h0003_0000;
    @(posedge pclk); #1;
    rd_chk("in_after_n1", A_IN, 32'h0003_0000);
    gpio_in = 32'h0;
    repeat (4) @(posedge pclk);
    #1;

    // Unmapped offsets fault and do not alias onto mask registers.
    apb(1'b1, 12'h030, 32'hFFFF_FFFF, 4'hF, r, e);
    chk("unmapped_wr_err", {31'h0, e}, 32'h1);
    apb(1'b0, 12'h030, 32'h0, 4'hF, r, e);
    chk("unmapped_rd_data", r, 32'h0);
    chk("unmapped_rd_err", {31'h0, e}, 32'h1);
    apb(1'b0, 12'h040, 32'h0, 4'hF, r, e);
    chk("unmapped_40_err", {31'h0, e}, 32'h1);
    rd_chk("mask0_untouched", A_M0, 32'h0);
    chk("out_untouched", gpio_out, 32'h25A5_0001);

    // Rising edge on pin 3 through to irq[1].
    wr(A_REN, 32'h8, 4'hF);
    wr(A_M1, 32'h8, 4'hF);
    gpio_in = 32'h8;
    @(posedge pclk); #1;
    chk("irq_at_n", {28'h0, irq}, 32'h0);
    PADDR = A_ST; PWRITE = 1'b0; PSTRB = 4'hF; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge pclk); #1;
    PENABLE = 1'b1;
    #1;
    chk("status_at_n1", PRDATA, 32'h0);
    chk("irq_at_n1", {28'h0, irq}, 32'h0);
    @(posedge pclk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    chk("irq_at_n2", {28'h0, irq}, 32'h0);
    @(posedge pclk); #1;
    chk("irq_at_n3", {28'h0, irq}, 32'h2);
    rd_chk("status_rise", A_ST, 32'h8);
    wr(A_ST, 32'h8, 4'hF);
    chk("irq_after_w1c_1", {28'h0, irq}, 32'h2);
    @(posedge pclk); #1;
    chk("irq_after_w1c_2", {28'h0, irq}, 32'h0);
    rd_chk("status_cleared", A_ST, 32'h0);

    // A fall event coinciding with its W1C keeps the bit set.
    wr(A_FEN, 32'h1, 4'hF);
    gpio_in = 32'h9;
    repeat (4) @(posedge pclk);
    #1;
    gpio_in = 32'h8;
    repeat (4) @(posedge pclk);
    #1;
    rd_chk("status_fall", A_ST, 32'h1);
    gpio_in = 32'h9;
    repeat (4) @(posedge pclk);
    #1;
    gpio_in = 32'h8;
    @(posedge pclk); #1;
    wr(A_ST, 32'h1, 4'hF);
    rd_chk("set_beats_clear", A_ST, 32'h1);

    // Reset during a write access phase with irq active.
    wr(A_M0, 32'h1, 4'hF);
    @(posedge pclk); #1;
    chk("irq_before_reset", {28'h0, irq}, 32'h1);
    PADDR = A_OUT; PWRITE = 1'b1; PWDATA = 32'hFFFF_FFFF; PSTRB = 4'hF;
    PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge pclk); #1;
    PENABLE = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_gpio_out", gpio_out, 32'h0);
    chk("midrst_irq", {28'h0, irq}, 32'h0);
    chk("midrst_pslverr", {31'h0, PSLVERR}, 32'h0);
    @(posedge pclk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(posedge pclk); #1;
    reset = 1'b0;
    rd_chk("post_rst_out", A_OUT, 32'h0);
    rd_chk("post_rst_dir", A_DIR, 32'h0);
    rd_chk("post_rst_ren", A_REN, 32'h0);
    rd_chk("post_rst_fen", A_FEN, 32'h0);
    rd_chk("post_rst_m0", A_M0, 32'h0);
    rd_chk("post_rst_m1", A_M1, 32'h0);
    rd_chk("post_rst_m2", A_M2, 32'h0);
    rd_chk("post_rst_m3", A_M3, 32'h0);
    chk("post_rst_gpio_out", gpio_out, 32'h0);
    chk("post_rst_irq", {28'h0, irq}, 32'h0);
    // Pin 3 stayed high across reset with edges disabled: nothing captured.
    rd_chk("post_rst_status", A_ST, 32'h0);
    rd_chk("post_rst_in", A_IN, 32'h8);

    // Randomised register traffic and pin transitions against the model.
    out_m = '0; dir_m = '0; ren_m = '0; fen_m = '0; st_m = '0;
    for (int k = 0; k < 4; k++) mask_m[k] = '0;
    oldg = 32'h8;
    for (int it = 0; it < 24; it++) begin
      for (int j = 0; j < 3; j++) begin
        sel = $urandom_range(0, 9);
        d   = $urandom;
        s   = 4'($urandom_range(0, 15));
        bm  = byte_mask(s);
        addr = A_OUT;
        case (sel)
          0: begin addr = A_OUT; out_m = (out_m & ~bm) | (d & bm); end
          1: begin addr = A_DIR; dir_m = (dir_m & ~bm) | (d & bm); end
          2: begin addr = A_SET; out_m = out_m | (d & bm); end
          3: begin addr = A_CLR; out_m = out_m & ~(d & bm); end
          4: begin addr = A_REN; ren_m = (ren_m & ~bm) | (d & bm); end
          5: begin addr = A_FEN; fen_m = (fen_m & ~bm) | (d & bm); end
          default: begin
            addr = A_M0 + 12'(4 * (sel - 6));
            mask_m[sel-6] = (mask_m[sel-6] & ~bm) | (d & bm);
          end
        endcase
        wr(addr, d, s);
        case (sel)
          0, 2, 3: begin rb_addr = A_OUT; exp_rb = out_m; end
          1:       begin rb_addr = A_DIR; exp_rb = dir_m; end
          4:       begin rb_addr = A_REN; exp_rb = ren_m; end
          5:       begin rb_addr = A_FEN; exp_rb = fen_m; end
          default: begin rb_addr = addr;  exp_rb = mask_m[sel-6]; end
        endcase
        rd_chk("rnd_readback", rb_addr, exp_rb);
      end
      chk("rnd_gpio_out", gpio_out, out_m);
      chk("rnd_gpio_dir", gpio_dir, dir_m);

      rd_chk("rnd_status_static", A_ST, st_m);
      wr(A_ST, 32'hFFFF_FFFF, 4'hF);
      st_m = '0;
      newg = $urandom;
      ev = (newg & ~oldg & ren_m) | (~newg & oldg & fen_m);
      gpio_in = newg;
      oldg = newg;
      repeat (5) @(posedge pclk);
      #1;
      st_m = st_m | ev;
      rd_chk("rnd_status_edges", A_ST, st_m);
      rd_chk("rnd_in", A_IN, newg);
      for (int k = 0; k < 4; k++) exp_irq[k] = |(st_m & mask_m[k]);
      chk("rnd_irq", {28'h0, irq}, {28'h0, exp_irq});

      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      bm = byte_mask(s);
      wr(A_ST, d, s);
      st_m = st_m & ~(d & bm);
      rd_chk("rnd_status_w1c", A_ST, st_m);
      for (int k = 0; k < 4; k++) exp_irq[k] = |(st_m & mask_m[k]);
      chk("rnd_irq_w1c", {28'h0, irq}, {28'h0, exp_irq});
    end

    // Narrow instance: bits above NPIN and masks beyond NIRQ.
    s_apb(1'b1, A_DIR, 32'hFFFF_FFFF, r, e);
    chk("small_dir_wr_err", {31'h0, e}, 32'h0);
    s_apb(1'b0, A_DIR, 32'h0, r, e);
    chk("small_dir_read", r, 32'h0000_00FF);
    chk("small_gpio_dir", {24'h0, s_gpio_dir}, 32'h0000_00FF);
    s_apb(1'b1, A_M1, 32'hFFFF_FFFF, r, e);
    chk("small_m1_wr_err", {31'h0, e}, 32'h0);
    s_apb(1'b0, A_M1, 32'h0, r, e);
    chk("small_m1_read", r, 32'h0000_00FF);
    s_apb(1'b0, A_M2, 32'h0, r, e);
    chk("small_28_data", r, 32'h0);
    chk("small_28_err", {31'h0, e}, 32'h1);
    s_apb(1'b1, A_M2, 32'hFFFF_FFFF, r, e);
    chk("small_28_wr_err", {31'h0, e}, 32'h1);
    s_apb(1'b0, A_M0, 32'h0, r, e);
    chk("small_m0_untouched", r, 32'h0);
    s_apb(1'b0, A_DIR, 32'h0, r, e);
    chk("small_dir_untouched", r, 32'h0000_00FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
